// File: rtl/mul_reconstruct_pkg.sv
// mul_reconstruct_pkg
// Shared constants and types for the shift-add multiplier-accumulator and the
// blocks that sit next to it (divider, top-level calculator datapath).
//   WIDTH_DEFAULT : operand width of the quotient/divisor pair
//   RESULT_W      : width of Q*M+R, one bit wider than the plain product
//   state_t       : multiplier FSM encoding
package mul_reconstruct_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int RESULT_W      = 2 * WIDTH_DEFAULT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'h0,
    CALC = 2'h1,
    ADD  = 2'h2,
    DONE = 2'h3
  } state_t;

endpackage

// File: rtl/mul_reconstruct_step.sv
// mul_step
// One iteration of the shift-add multiplier: conditionally add the
// multiplicand into the accumulator, then shift {acc, q} right by one with
// the adder carry entering the accumulator MSB.
// Ports:
//   acc_i / acc_o : WIDTH+1 bit accumulator, before / after the step
//   q_i   / q_o   : WIDTH bit multiplier shift register, before / after
//   m_i           : WIDTH bit multiplicand
module mul_step
  import mul_reconstruct_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o
);

  // The sum is kept one bit wider than the accumulator so the carry out of
  // the add is never lost; it falls into acc_o's MSB after the shift.
  logic [WIDTH+1:0] sum;

  always_comb begin
    sum   = {1'b0, acc_i} + (q_i[0] ? {2'b00, m_i} : '0);
    acc_o = sum[WIDTH+1:1];
    q_o   = {sum[0], q_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_reconstruct.sv
// mul_reconstruct
// Sequential unsigned shift-add multiplier-accumulator: P = Q*M + R.
// It undoes the divider (quotient * divisor + remainder = dividend) and uses
// the same start/done handshake.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   parser_done  : start pulse, operands valid in that cycle
//   Q, M         : WIDTH bit multiplier and multiplicand
//   R            : WIDTH+1 bit addend
//   P            : 2*WIDTH+1 bit result, held until the next ADD
//   mul_done     : one-cycle pulse, P valid from that cycle
//   busy         : high while in CALC or ADD
// Build option:
//   MUL_ZERO_BYPASS_EN : when defined, a start with Q==0 or M==0 skips CALC
//                        and produces P=R two cycles after the start.
module mul_reconstruct
  import mul_reconstruct_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               parser_done,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH:0]     R,
  output logic [2*WIDTH:0]   P,
  output logic               mul_done,
  output logic               busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [2*WIDTH:0]   p_q, p_d;

  logic [WIDTH:0]     step_acc;
  logic [WIDTH-1:0]   step_q;
  logic               zero_bypass;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .q_o   (step_q)
  );

  // A zero operand makes the product zero, so the iterations can be skipped
  // and only the addend needs to pass through ADD.
`ifdef MUL_ZERO_BYPASS_EN
  assign zero_bypass = (Q == '0) || (M == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  // Next-state and datapath update. Starts are only honoured in IDLE, so a
  // held or repeated parser_done during an operation is simply dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    r_d     = r_q;
    p_d     = p_q;

    unique case (state_q)
      IDLE: begin
        if (parser_done) begin
          m_d     = M;
          r_d     = R;
          q_d     = Q;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
          if (zero_bypass) begin
            q_d     = '0;
            state_d = ADD;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ADD;
        end
      end
      ADD: begin
        // The full-width sum reaches exactly 2^(2*WIDTH) at most, which
        // still fits in 2*WIDTH+1 bits.
        p_d     = {acc_q, q_q} + {{WIDTH{1'b0}}, r_q};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      r_q     <= r_d;
      p_q     <= p_d;
    end
  end

  assign P        = p_q;
  assign mul_done = (state_q == DONE);
  assign busy     = (state_q == CALC) || (state_q == ADD);

endmodule

// File: tb/tb_mul_reconstruct.sv
// tb_mul_reconstruct
// Scoreboard bench for mul_reconstruct: every start pushes Q*M+R and the
// expected start-to-done latency; each mul_done pops and compares.
module tb_mul_reconstruct;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           parser_done;
  logic [W-1:0]   q_in;
  logic [W-1:0]   m_in;
  logic [W:0]     r_in;
  logic [2*W:0]   p_out;
  logic           mul_done;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;

  logic [2*W:0] exp_q[$];
  int           lat_q[$];
  int           start_q[$];

  bit  op_active = 1'b0;
  int  op_start = 0;
  int  op_lat = 0;
  int  mon_rel;
  int  mon_start;
  int  mon_lat;
  logic [2*W:0] mon_exp;

  mul_reconstruct #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .parser_done (parser_done),
    .Q           (q_in),
    .M           (m_in),
    .R           (r_in),
    .P           (p_out),
    .mul_done    (mul_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive a real start for one cycle and record what must come back.
  task automatic applyStimulus(input logic [W-1:0] q, input logic [W-1:0] m,
                               input logic [W:0] r);
    longint unsigned e;
    int lat;
    e   = longint'(q) * longint'(m) + longint'(r);
    lat = W + 2;
`ifdef MUL_ZERO_BYPASS_EN
    if (q == '0 || m == '0) lat = 2;
`endif
    @(posedge clk); #1;
    q_in = q;
    m_in = m;
    r_in = r;
    parser_done = 1'b1;
    exp_q.push_back(e[2*W:0]);
    lat_q.push_back(lat);
    start_q.push_back(cyc);
    op_active = 1'b1;
    op_start  = cyc;
    op_lat    = lat;
    @(posedge clk); #1;
    parser_done = 1'b0;
  endtask

  // Drive a start that the DUT must ignore; nothing is expected from it.
  task automatic applyIgnoredStart(input logic [W-1:0] q, input logic [W-1:0] m,
                                   input logic [W:0] r);
    q_in = q;
    m_in = m;
    r_in = r;
    parser_done = 1'b1;
    @(posedge clk); #1;
    parser_done = 1'b0;
  endtask

  task automatic flushScoreboard();
    exp_q.delete();
    lat_q.delete();
    start_q.delete();
    op_active = 1'b0;
  endtask

  // Bounded wait for every outstanding result to be popped.
  task automatic waitDone();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checkOutput("timeout", 64'(0), 64'(1));
      flushScoreboard();
    end
    @(posedge clk); #1;
  endtask

  // Output monitor on the falling edge: busy window and scoreboard pops.
  always @(negedge clk) begin
    if (!rst) begin
      if (op_active) begin
        mon_rel = cyc - op_start;
        checkOutput("busy", 64'(busy), 64'(mon_rel >= 1 && mon_rel <= op_lat - 1));
      end
      if (mul_done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_done", 64'(1), 64'(0));
        end else begin
          mon_exp   = exp_q.pop_front();
          mon_lat   = lat_q.pop_front();
          mon_start = start_q.pop_front();
          checkOutput("P", 64'(p_out), 64'(mon_exp));
          checkOutput("latency", 64'(cyc - mon_start), 64'(mon_lat));
          op_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    logic [W-1:0] rq, rm;
    logic [W:0]   rr;

    rst = 1'b1;
    parser_done = 1'b0;
    q_in = '0;
    m_in = '0;
    r_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_P", 64'(p_out), 64'(0));
    checkOutput("rst_done", 64'(mul_done), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    // Basic product and hold after done.
    applyStimulus(16'd7, 16'd3, 17'd2);
    waitDone();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("P_hold", 64'(p_out), 64'h17);

    // Largest operands: result needs the full 33 bits.
    applyStimulus(16'hFFFF, 16'hFFFF, 17'h1FFFF);
    waitDone();
    checkOutput("P_max", 64'(p_out), 64'h1_0000_0000);

    // Divider round trip: 1000 / 7 = 142 rem 6.
    applyStimulus(16'd142, 16'd7, 17'd6);
    waitDone();
    checkOutput("roundtrip", 64'(p_out), 64'd1000);

    // Second start in the middle of an operation must be dropped.
    dc = done_count;
    applyStimulus(16'd5, 16'd5, 17'd0);
    repeat (4) @(posedge clk);
    #1;
    applyIgnoredStart(16'd9, 16'd9, 17'd0);
    waitDone();
    repeat (25) @(posedge clk);
    #1;
    checkOutput("single_done", 64'(done_count - dc), 64'(1));
    checkOutput("P_ignore", 64'(p_out), 64'd25);

    // parser_done held for two cycles starts only one operation.
    dc = done_count;
    applyStimulus(16'd11, 16'd13, 17'd4);
    applyIgnoredStart(16'd1, 16'd1, 17'd1);
    waitDone();
    repeat (25) @(posedge clk);
    #1;
    checkOutput("held_start_done", 64'(done_count - dc), 64'(1));

    // Reset in the middle of CALC.
    dc = done_count;
    applyStimulus(16'd100, 16'd50, 17'd3);
    repeat (9) @(posedge clk);
    #1;
    flushScoreboard();
    rst = 1'b1;
    #1;
    checkOutput("midrst_P", 64'(p_out), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_done", 64'(mul_done), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("no_done_after_rst", 64'(done_count - dc), 64'(0));
    applyStimulus(16'd2, 16'd3, 17'd1);
    waitDone();
    checkOutput("P_after_rst", 64'(p_out), 64'd7);

    // Zero operand: latency depends on the bypass build option.
    applyStimulus(16'd0, 16'd1234, 17'd5);
    waitDone();
    checkOutput("P_zero", 64'(p_out), 64'd5);
    applyStimulus(16'd77, 16'd0, 17'h1FFFF);
    waitDone();

    // A handful of random operations.
    for (int i = 0; i < 6; i++) begin
      rq = W'($urandom);
      rm = W'($urandom);
      rr = (W + 1)'($urandom);
      applyStimulus(rq, rm, rr);
      waitDone();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
